sdram_burst_reader: RTL
=======================

# sdram_burst_reader

Parametrised single-clock Avalon-bridge master that streams a block of consecutive SDRAM words into an on-chip buffer for a downstream consumer. It replaces the fixed single-address reader in the SDRAM tester. It adds programmable base address and length, credit-based flow control against a show-ahead FIFO, and a start/busy/done control handshake. An optional pre-fill pass writes a deterministic pattern to the same region before it is read back.

## Interface
- INTERFACE_WIDTH_BITS, 128, bus data width; must be a multiple of 32.
- NUM_BUFFER_ENTRIES, 64, FIFO depth in words; must be a power of two and at least 2.
- INTERFACE_ADDR_BITS, 26, byte-address width of the bridge.

- interface_clock  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin; sampled only in IDLE.
- base_address  in  INTERFACE_ADDR_BITS  byte address of the first word; captured on start.
- word_count  in  INTERFACE_ADDR_BITS  number of words to transfer; captured on start.
- fill_seed  in  32  pattern seed; captured on start; ignored unless fill is compiled in.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the job completes.
- interface_address  out  INTERFACE_ADDR_BITS  request byte address.
- interface_byte_enable  out  INTERFACE_WIDTH_BITS/8  all ones whenever a request is active, otherwise zero.
- interface_read  out  1  read request.
- interface_write  out  1  write request.
- interface_write_data  out  INTERFACE_WIDTH_BITS  write payload.
- interface_read_data  in  INTERFACE_WIDTH_BITS  read payload; valid in the cycle interface_acknowledge is high.
- interface_acknowledge  in  1  completes the current request.
- data_out  out  INTERFACE_WIDTH_BITS  FIFO head.
- data_valid  out  1  FIFO is not empty.
- data_ready  in  1  consumer pop; a pop occurs on data_valid && data_ready.

## Operation
- States: IDLE, FILL, READ, DRAIN, DONE. FILL exists only when fill is compiled in.
- BYTES = INTERFACE_WIDTH_BITS/8. Word i is at address base_address + i*BYTES, taken modulo 2^INTERFACE_ADDR_BITS, so the address wraps silently.
- IDLE:
  - start=1 with word_count=0 goes to DONE.
  - start=1 with word_count>0 goes to FILL if compiled in, otherwise READ.
- While busy, start is ignored.
- At most one bus request is outstanding. Request signals and address stay constant until acknowledge.
- FILL:
  - Write words 0..N-1.
  - Payload for word i is (fill_seed + i) mod 2^32, replicated across the bus width.
  - After the last acknowledge, restart the index at 0 and go to READ.
- READ:
  - A read is issued only if fifo_count + outstanding < NUM_BUFFER_ENTRIES. This credit rule makes FIFO overflow impossible.
  - Each acknowledge pushes interface_read_data into the FIFO.
  - After the acknowledge of word N-1, go to DRAIN.
- DRAIN: wait for the FIFO to empty, then go to DONE.
- DONE: pulse done for one cycle, then return to IDLE. Inputs captured for the next start are sampled afresh.
- FIFO push and pop in the same cycle leaves the count unchanged. This is legal at both full and empty; at empty, data_valid is already low, so no pop can occur.
- The word counter is INTERFACE_ADDR_BITS wide. Arithmetic is unsigned and wraps.

## Timing
- Reset values:
  - State IDLE.
  - busy, done, interface_read, interface_write = 0.
  - interface_byte_enable, interface_address, interface_write_data = 0.
  - FIFO empty, so data_valid = 0; data_out = 0.
- Reset asserted mid-job aborts the job immediately (asynchronously). The bus request drops and the FIFO contents are discarded.
- Start is accepted at edge T. The first request is asserted from T+1.
- Acknowledge at edge T: the next request, if permitted, is presented from T+1 with the next address, with no idle cycle. Otherwise the request deasserts at T+1.
- A read acknowledged at edge T produces data_valid=1 and the data on data_out from T+1. Read latency into the FIFO is 1 cycle.
- done rises one cycle after the FIFO becomes empty in DRAIN. busy falls in the same cycle done rises.
- An acknowledge arriving while no request is active is ignored.

## Configuration
- SDRAM_BURST_READER_FILL_EN
  - Defined: the FILL state, pattern generator and write path are built. interface_write and interface_write_data are driven as described above.
  - Undefined: the FILL state is absent. interface_write is tied to 0, interface_write_data to 0, and fill_seed is unused. Start goes directly to READ.

## Structure
- sdram_burst_reader_pkg contains:
  - the state enum typedef;
  - a localparam function returning bytes per word;
  - the pattern function fill_word(seed, index).
- Sub-module sdram_burst_fifo: single-clock, show-ahead, parameterised width and depth. It exposes count, full and empty; write and read pointers are one bit wider than the address for the full/empty test. The top-level block owns the FSM, address/word counters and credit logic.

## Test plan
- Read without fill: base=0x100, count=4, acknowledge after 2 cycles, data_ready=1. Expect reads to addresses 0x100, 0x110, 0x120, 0x130, the four read words delivered in order, done 1 cycle after the last pop, busy low afterwards.
- Backpressure: count=100, depth 64, data_ready=0. Expect exactly 64 reads, then the request stays low. Release data_ready and expect all 100 words delivered with no loss or duplication.
- Fill enabled: seed=0xA5A5_0000, count=3. Expect write payloads 0xA5A50000, 0xA5A50001 and 0xA5A50002, each replicated across the bus width, followed by three reads of the same addresses. The read-back equals the fill payloads when a memory model is attached.
- Edges:
  - count=0 gives done 1 cycle after start with no bus activity.
  - base=0x3FFFFF0 with count=2 wraps the second address to 0x0000000.
  - start while busy is ignored.
- Reset mid-READ: assert reset_n=0 during an outstanding request. Expect read, busy and data_valid to go 0 immediately. A new start after reset runs cleanly.

Source files
------------

// File: rtl/sdram_burst_reader_pkg.sv
// Shared types and helpers for the SDRAM burst reader.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sdram_burst_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Bytes carried by one bus word; used for the per-word address stride.
  function automatic int unsigned bytes_per_word(input int unsigned width_bits);
    return width_bits / 8;
  endfunction

  // Pre-fill pattern for word <index>: seed plus index, wrapping at 32 bits.
  function automatic logic [31:0] fill_word(input logic [31:0] seed, input logic [31:0] index);
    return seed + index;
  endfunction

endpackage

// File: rtl/sdram_burst_fifo.sv
// Single-clock show-ahead FIFO: head_o shows the oldest entry whenever empty_o is low.
// Latency: a push is visible at head_o the cycle after the push edge.
// Backpressure: push while full is accepted only together with a pop; pop while empty is ignored.
module sdram_burst_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Head reads as zero while empty so stale storage never shows on the output.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  // Pointer update; reset discards all contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/sdram_burst_reader.sv
// Bus master streaming word_count words from base_address into a show-ahead FIFO; define SDRAM_BURST_READER_FILL_EN for a pattern pre-fill pass.
// Latency: first request the cycle after start is accepted; read data on data_out the cycle after acknowledge.
// Backpressure: one request outstanding; reads issue only while FIFO credit remains, so a stalled consumer stalls the bus, never drops data.
module sdram_burst_reader
  import sdram_burst_reader_pkg::*;
#(
  parameter int INTERFACE_WIDTH_BITS = 128,
  parameter int NUM_BUFFER_ENTRIES   = 64,
  parameter int INTERFACE_ADDR_BITS  = 26
) (
  input  logic                              interface_clock,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [INTERFACE_ADDR_BITS-1:0]    base_address,
  input  logic [INTERFACE_ADDR_BITS-1:0]    word_count,
  input  logic [31:0]                       fill_seed,
  output logic                              busy,
  output logic                              done,
  output logic [INTERFACE_ADDR_BITS-1:0]    interface_address,
  output logic [INTERFACE_WIDTH_BITS/8-1:0] interface_byte_enable,
  output logic                              interface_read,
  output logic                              interface_write,
  output logic [INTERFACE_WIDTH_BITS-1:0]   interface_write_data,
  input  logic [INTERFACE_WIDTH_BITS-1:0]   interface_read_data,
  input  logic                              interface_acknowledge,
  output logic [INTERFACE_WIDTH_BITS-1:0]   data_out,
  output logic                              data_valid,
  input  logic                              data_ready
);

  localparam int AW  = $clog2(NUM_BUFFER_ENTRIES);
  localparam int BE  = INTERFACE_WIDTH_BITS / 8;
  localparam logic [INTERFACE_ADDR_BITS-1:0] STEP    = INTERFACE_ADDR_BITS'(bytes_per_word(INTERFACE_WIDTH_BITS));
  localparam logic [INTERFACE_ADDR_BITS-1:0] ONE     = INTERFACE_ADDR_BITS'(1);
  localparam logic [AW:0]                    DEPTH_W = (AW+1)'(NUM_BUFFER_ENTRIES);

  state_e                         state_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           read_q;
  logic [INTERFACE_ADDR_BITS-1:0] address_q;
  logic [INTERFACE_ADDR_BITS-1:0] idx_q;
  logic [INTERFACE_ADDR_BITS-1:0] len_q;

  logic        req_active;
  logic        ack;
  logic        last_word;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic [AW:0] fifo_count_d;
  logic        credit_ok;

`ifdef SDRAM_BURST_READER_FILL_EN
  localparam int REP = INTERFACE_WIDTH_BITS / 32;
  logic                            write_q;
  logic [INTERFACE_WIDTH_BITS-1:0] write_data_q;
  logic [INTERFACE_ADDR_BITS-1:0]  base_q;
  logic [31:0]                     seed_q;
  assign req_active           = read_q | write_q;
  assign interface_write      = write_q;
  assign interface_write_data = write_data_q;
`else
  logic unused_fill_seed;
  assign unused_fill_seed     = ^fill_seed;
  assign req_active           = read_q;
  assign interface_write      = 1'b0;
  assign interface_write_data = '0;
`endif

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign interface_read        = read_q;
  assign interface_address     = address_q;
  assign interface_byte_enable = {BE{req_active}};

  // An acknowledge only counts while a request is actually on the bus.
  assign ack       = interface_acknowledge && req_active;
  assign last_word = (idx_q == len_q - ONE);

  // Credit keeps room for every outstanding read, so the full guard never blocks.
  assign data_valid   = !fifo_empty;
  assign fifo_pop     = data_valid && data_ready;
  assign fifo_push    = ack && read_q && (!fifo_full || fifo_pop);
  assign fifo_count_d = fifo_count + {{AW{1'b0}}, fifo_push} - {{AW{1'b0}}, fifo_pop};
  assign credit_ok    = (fifo_count_d < DEPTH_W);

  sdram_burst_fifo #(
    .WIDTH (INTERFACE_WIDTH_BITS),
    .DEPTH (NUM_BUFFER_ENTRIES)
  ) u_fifo (
    .clk_i       (interface_clock),
    .rst_ni      (reset_n),
    .push_i      (fifo_push),
    .push_data_i (interface_read_data),
    .pop_i       (fifo_pop),
    .head_o      (data_out),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Job sequencer: owns state, bus request registers, address and word index.
  always_ff @(posedge interface_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      read_q       <= 1'b0;
      address_q    <= '0;
      idx_q        <= '0;
      len_q        <= '0;
`ifdef SDRAM_BURST_READER_FILL_EN
      write_q      <= 1'b0;
      write_data_q <= '0;
      base_q       <= '0;
      seed_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q     <= word_count;
            idx_q     <= '0;
            address_q <= base_address;
            if (word_count == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              busy_q <= 1'b1;
`ifdef SDRAM_BURST_READER_FILL_EN
              base_q       <= base_address;
              seed_q       <= fill_seed;
              write_q      <= 1'b1;
              write_data_q <= {REP{fill_word(fill_seed, 32'd0)}};
              state_q      <= ST_FILL;
`else
              read_q  <= 1'b1;
              state_q <= ST_READ;
`endif
            end
          end
        end
`ifdef SDRAM_BURST_READER_FILL_EN
        ST_FILL: begin
          if (ack) begin
            if (last_word) begin
              // FIFO is empty here, so the first read can follow immediately.
              write_q      <= 1'b0;
              write_data_q <= '0;
              idx_q        <= '0;
              address_q    <= base_q;
              read_q       <= 1'b1;
              state_q      <= ST_READ;
            end else begin
              idx_q        <= idx_q + ONE;
              address_q    <= address_q + STEP;
              write_data_q <= {REP{fill_word(seed_q, 32'(idx_q) + 32'd1)}};
            end
          end
        end
`endif
        ST_READ: begin
          if (ack) begin
            // Address advances even when credit stalls the next read, so it is ready on resume.
            address_q <= address_q + STEP;
            if (last_word) begin
              read_q  <= 1'b0;
              state_q <= ST_DRAIN;
            end else begin
              idx_q  <= idx_q + ONE;
              read_q <= credit_ok;
            end
          end else if (!read_q) begin
            read_q <= credit_ok;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
